// File: rtl/restador_serial_pkg.sv
// rtl/restador_serial_pkg.sv - shared state encoding, default width and reference result for restador_serial
package restador_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reference a - b for a width of w bits, truncated to w+1 bits (w <= 16).
    function automatic logic [16:0] ref_diff(input int unsigned w, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] mask;
        mask = (17'h1 << (w + 1)) - 17'h1;
        return ({1'b0, a} - {1'b0, b}) & mask;
    endfunction

endpackage

// File: rtl/restador_serial_if.sv
// rtl/restador_serial_if.sv - start/done operand interface of restador_serial (op present with RESTADOR_SUMA_EN)
interface restador_serial_if
    import restador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef RESTADOR_SUMA_EN
    logic             op;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   diff;

`ifdef RESTADOR_SUMA_EN
    modport master (output start, a, b, op, input ready, busy, done, diff);
    modport slave  (input start, a, b, op, output ready, busy, done, diff);
`else
    modport master (output start, a, b, input ready, busy, done, diff);
    modport slave  (input start, a, b, output ready, busy, done, diff);
`endif
endinterface

// File: rtl/restador_serial_celda.sv
// rtl/restador_serial_celda.sv - one-bit full subtractor cell (full adder/subtractor with RESTADOR_SUMA_EN)
module celda_restador (
`ifdef RESTADOR_SUMA_EN
    input  logic op,
`endif
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic bout_sub;

    assign d        = a ^ b ^ bin;
    assign bout_sub = (~a & b) | (~(a ^ b) & bin);

`ifdef RESTADOR_SUMA_EN
    // With op=1 the borrow chain becomes a carry chain.
    assign bout = op ? ((a & b) | (bin & (a ^ b))) : bout_sub;
`else
    assign bout = bout_sub;
`endif
endmodule

// File: rtl/restador_serial.sv
// rtl/restador_serial.sv - bit-serial LSB-first subtractor, one bit per clock; RESTADOR_SUMA_EN adds op-selected addition
module restador_serial
    import restador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    restador_serial_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [WIDTH-2:0]   res;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     diff_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               cell_d;
    logic               cell_bout;
`ifdef RESTADOR_SUMA_EN
    logic               opr;
`endif

    celda_restador u_celda (
`ifdef RESTADOR_SUMA_EN
        .op   (opr),
`endif
        .a    (ra[0]),
        .b    (rb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            res     <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            diff_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RESTADOR_SUMA_EN
            opr     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra      <= bus.a;
                        rb      <= bus.b;
                        res     <= '0;
                        br      <= 1'b0;
                        cnt     <= '0;
`ifdef RESTADOR_SUMA_EN
                        opr     <= bus.op;
`endif
                        state   <= SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    // res holds the WIDTH-1 low result bits; the newest bit enters at the top.
                    res <= (WIDTH-1)'({cell_d, res} >> 1);
                    br  <= cell_bout;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff_q <= {cell_bout, cell_d, res};
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
endmodule
